// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: hunts a sync byte, captures a 37-bit frame plus parity, applies it on good parity.
// Outputs registered on K; CFG/DONE update on the parity edge (46 valid bits per frame); DVALID=0 freezes all capture state.
module clb_cfg_loader #(
  parameter logic [7:0] SYNC = 8'hB2,
  parameter int         CFGW = 37
) (
  input  logic            K,
  input  logic            RSTN,
  input  logic            DIN,
  input  logic            DVALID,
  output logic [CFGW-1:0] CFG,
  output logic            DONE,
  output logic            ERR,
  output logic            BUSY
);

  // CLB power-on configuration: MEM, COMBOPT, MUX2..6SEL, O2M_0, O2M_1, DQMUX, FLOPORLATCH
  localparam logic [CFGW-1:0] CFG_RST = {16'h0116, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                                         3'b000, 3'b111, 2'b00, 1'b0};
  localparam logic [5:0] LAST_BIT = 6'(CFGW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state;
  logic [7:0]      window;
  logic [CFGW-1:0] shadow;
  logic [5:0]      cnt;
  logic            par;
  logic [7:0]      win_next;

  assign win_next = {window[6:0], DIN};

  always_ff @(posedge K or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      window <= 8'h00;
      shadow <= '0;
      cnt    <= 6'd0;
      par    <= 1'b0;
      CFG    <= CFG_RST;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (DVALID) begin
        case (state)
          IDLE: begin
            window <= win_next;
            if (win_next == SYNC) begin
              state <= LOAD;
              cnt   <= 6'd0;
              par   <= 1'b0;
              ERR   <= 1'b0;
              BUSY  <= 1'b1;
            end
          end
          LOAD: begin
            shadow <= {shadow[CFGW-2:0], DIN};
            par    <= par ^ DIN;
            if (cnt == LAST_BIT) begin
              state <= CHECK;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          CHECK: begin
            // Even parity over payload plus parity bit means the running parity equals the parity bit.
            if (par == DIN) begin
              CFG  <= shadow;
              DONE <= 1'b1;
            end else begin
              ERR <= 1'b1;
            end
            state  <= IDLE;
            window <= 8'h00;
            BUSY   <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader with a DONE-triggered scoreboard of expected CFG words.
module tb_clb_cfg_loader;

  logic        K = 1'b0;
  logic        RSTN;
  logic        DIN;
  logic        DVALID;
  logic [36:0] CFG;
  logic        DONE;
  logic        ERR;
  logic        BUSY;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int busy_cnt    = 0;

  logic [36:0] exp_q[$];
  int          done_cyc[$];

  localparam logic [36:0] CFG_DEF = {16'h0116, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                                     3'b000, 3'b111, 2'b00, 1'b0};
  localparam logic [36:0] P1 = {16'h8001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01,
                                3'b000, 3'b000, 2'b00, 1'b1};
  localparam logic [36:0] P2 = {16'h00B2, 2'b11, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11,
                                3'b101, 3'b010, 2'b10, 1'b0};
  localparam logic [36:0] P3 = {16'h5A5A, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b10,
                                3'b110, 3'b001, 2'b11, 1'b0};
  localparam logic [36:0] P4 = {16'h1234, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10,
                                3'b011, 3'b100, 2'b01, 1'b1};

  clb_cfg_loader dut (
    .K      (K),
    .RSTN   (RSTN),
    .DIN    (DIN),
    .DVALID (DVALID),
    .CFG    (CFG),
    .DONE   (DONE),
    .ERR    (ERR),
    .BUSY   (BUSY)
  );

  initial forever #5 K = ~K;

  always @(posedge K) cyc = cyc + 1;

  // Scoreboard monitor: every DONE pulse must match the oldest pending good frame.
  always @(negedge K) begin
    if (BUSY === 1'b1) busy_cnt = busy_cnt + 1;
    if (DONE === 1'b1) begin
      done_cyc.push_back(cyc);
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL done_unexpected: CFG=%h with no good frame pending", CFG);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if (CFG !== e) begin
          miscompares = miscompares + 1;
          $display("FAIL cfg_on_done: got %h expected %h", CFG, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [45:0] mk_frame(input logic [36:0] p, input logic badpar);
    return {8'hB2, p, (^p) ^ badpar};
  endfunction

  task automatic send_bit(input logic b, input logic v);
    DIN    = b;
    DVALID = v;
    @(posedge K);
    #1;
  endtask

  task automatic send_frame(input logic [36:0] p, input logic badpar);
    logic [45:0] f;
    f = mk_frame(p, badpar);
    for (int i = 45; i >= 0; i--) send_bit(f[i], 1'b1);
    DVALID = 1'b0;
  endtask

  initial begin
    logic [45:0] f;
    logic [15:0] pre;
    int          nd;
    int          gaps_busy;

    RSTN   = 1'b1;
    DIN    = 1'b0;
    DVALID = 1'b0;
    #2 RSTN = 1'b0;

    // Reset state
    repeat (2) @(posedge K);
    #1;
    chk("rst_cfg_async", 64'(CFG), 64'(CFG_DEF));
    RSTN = 1'b1;
    send_bit(1'b0, 1'b0);
    chk("rst_cfg", 64'(CFG), 64'(CFG_DEF));
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_err", 64'(ERR), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);

    // Good frame, continuous DVALID, with per-edge checks
    f        = mk_frame(P1, 1'b0);
    busy_cnt = 0;
    exp_q.push_back(P1);
    for (int i = 0; i < 46; i++) begin
      send_bit(f[45-i], 1'b1);
      if (i < 45) begin
        chk("good_done_early", 64'(DONE), 64'd0);
        chk("good_cfg_early", 64'(CFG), 64'(CFG_DEF));
      end
      if (i == 6) chk("good_busy_pre_sync", 64'(BUSY), 64'd0);
      if (i == 7) chk("good_busy_at_sync", 64'(BUSY), 64'd1);
    end
    chk("good_done_pulse", 64'(DONE), 64'd1);
    chk("good_cfg", 64'(CFG), 64'(P1));
    chk("good_busy_fall", 64'(BUSY), 64'd0);
    send_bit(1'b0, 1'b0);
    chk("good_done_one_cycle", 64'(DONE), 64'd0);
    chk("good_busy_len", 64'(busy_cnt), 64'd38);

    // Bad parity: CFG held, ERR sticky, no DONE
    nd = done_cyc.size();
    send_frame(P3, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("bad_cfg_held", 64'(CFG), 64'(P1));
    chk("bad_err", 64'(ERR), 64'd1);
    chk("bad_no_done", 64'(done_cyc.size()), 64'(nd));
    send_bit(1'b0, 1'b0);
    chk("bad_err_sticky", 64'(ERR), 64'd1);

    // Good follow-up clears ERR at the sync match
    f = mk_frame(P3, 1'b0);
    exp_q.push_back(P3);
    for (int i = 0; i < 46; i++) begin
      send_bit(f[45-i], 1'b1);
      if (i == 6) chk("clr_err_before_sync", 64'(ERR), 64'd1);
      if (i == 7) chk("clr_err_at_sync", 64'(ERR), 64'd0);
    end
    DVALID = 1'b0;
    send_bit(1'b0, 1'b0);
    chk("clr_cfg", 64'(CFG), 64'(P3));
    chk("clr_err_after", 64'(ERR), 64'd0);

    // Gapped DVALID, with a forced gap in sync and right after the parity bit
    f         = mk_frame(P1, 1'b0);
    nd        = done_cyc.size();
    gaps_busy = 0;
    busy_cnt  = 0;
    exp_q.push_back(P1);
    for (int i = 0; i < 46; i++) begin
      if (i == 3 || i == 20 || $urandom_range(0, 3) == 0) begin
        send_bit(1'($urandom_range(0, 1)), 1'b0);
        if (i >= 8) gaps_busy++;
      end
      send_bit(f[45-i], 1'b1);
    end
    chk("gap_done_pulse", 64'(DONE), 64'd1);
    send_bit(1'b1, 1'b0);
    chk("gap_done_one_cycle", 64'(DONE), 64'd0);
    chk("gap_cfg", 64'(CFG), 64'(P1));
    chk("gap_done_count", 64'(done_cyc.size()), 64'(nd + 1));
    chk("gap_busy_len", 64'(busy_cnt), 64'(38 + gaps_busy));

    // Sync hunt A: match only at the second preamble byte
    pre = 16'b1011_0011_1011_0010;
    f   = mk_frame(P4, 1'b0);
    nd  = done_cyc.size();
    exp_q.push_back(P4);
    for (int i = 0; i < 16; i++) begin
      send_bit(pre[15-i], 1'b1);
      if (i < 15) chk("hunt_a_no_early_match", 64'(BUSY), 64'd0);
    end
    chk("hunt_a_match", 64'(BUSY), 64'd1);
    for (int i = 37; i >= 0; i--) send_bit(f[i], 1'b1);
    DVALID = 1'b0;
    send_bit(1'b0, 1'b0);
    chk("hunt_a_done_count", 64'(done_cyc.size()), 64'(nd + 1));

    // Sync hunt B: B2 inside the payload must not restart the capture
    nd       = done_cyc.size();
    busy_cnt = 0;
    exp_q.push_back(P2);
    send_frame(P2, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("hunt_b_cfg", 64'(CFG), 64'(P2));
    chk("hunt_b_busy_len", 64'(busy_cnt), 64'd38);
    chk("hunt_b_done_count", 64'(done_cyc.size()), 64'(nd + 1));

    // Sync hunt C: back-to-back frames
    nd = done_cyc.size();
    exp_q.push_back(P1);
    exp_q.push_back(P3);
    f = mk_frame(P1, 1'b0);
    for (int i = 45; i >= 0; i--) send_bit(f[i], 1'b1);
    f = mk_frame(P3, 1'b0);
    for (int i = 45; i >= 0; i--) send_bit(f[i], 1'b1);
    DVALID = 1'b0;
    send_bit(1'b0, 1'b0);
    chk("b2b_done_count", 64'(done_cyc.size()), 64'(nd + 2));
    if (done_cyc.size() >= nd + 2)
      chk("b2b_done_spacing", 64'(done_cyc[nd+1] - done_cyc[nd]), 64'd46);
    chk("b2b_cfg", 64'(CFG), 64'(P3));

    // Reset mid-frame after payload bit 20
    f = mk_frame(P4, 1'b0);
    for (int i = 45; i >= 45 - 27; i--) send_bit(f[i], 1'b1);
    chk("mid_busy_before_rst", 64'(BUSY), 64'd1);
    #1 RSTN = 1'b0;
    #1;
    chk("mid_rst_cfg", 64'(CFG), 64'(CFG_DEF));
    chk("mid_rst_busy", 64'(BUSY), 64'd0);
    chk("mid_rst_err", 64'(ERR), 64'd0);
    DVALID = 1'b0;
    @(posedge K);
    #1 RSTN = 1'b1;
    send_bit(1'b0, 1'b0);
    chk("mid_cfg_after_release", 64'(CFG), 64'(CFG_DEF));
    exp_q.push_back(P4);
    send_frame(P4, 1'b0);
    repeat (3) send_bit(1'b0, 1'b0);
    chk("mid_reload_cfg", 64'(CFG), 64'(P4));
    chk("pending_frames", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
